bus_mux_reg: RTL and testbench
==============================

// Module: bus_mux_reg
// PURPOSE
//   Parametrised, registered datapath bus multiplexer for the CPU.
//   Selects one of NSRC source registers onto a WIDTH-bit bus using per-source drive enables.
//   Fixed priority: the highest-index active enable wins.
//   Adds a one-cycle output register, hold-on-idle, source-index reporting and a saturating
//   transfer counter. Optionally adds multi-driver contention detection.
//   Sits between the register file/special registers (HI, LO, MDR, Z, ...) and all bus consumers.
// PARAMETERS
//   WIDTH  32             bus and source data width in bits
//   NSRC   24             number of bus sources (>= 2)
//   IDX_W  $clog2(NSRC)   width of the source index output
//   CNT_W  16             transfer counter width
// PORTS
//   clock          in   1            system clock, rising edge
//   clear_n        in   1            asynchronous, active-low reset
//   src_out        in   NSRC         drive enables; bit i requests source i onto the bus
//   src_data       in   NSRC*WIDTH   flattened source data; source i at [i*WIDTH +: WIDTH]
//   hold_en        in   1            1 = freeze all registered outputs this cycle
//   cnt_clr        in   1            synchronous clear of xfer_cnt
//   conflict_clr   in   1            synchronous clear of contention status (macro only)
//   bus_out        out  WIDTH        registered bus value
//   bus_valid      out  1            1 = bus_out was driven by a source in the previous cycle
//   bus_src        out  IDX_W        index of the source that drove bus_out
//   xfer_cnt       out  CNT_W        number of driven cycles, saturating
//   bus_conflict   out  1            sticky multi-driver flag (macro only)
//   conflict_mask  out  NSRC         src_out captured at the first conflict (macro only)
// BEHAVIOUR
//   Reset: clear_n low asynchronously forces all outputs to 0.
//     Affects bus_out, bus_valid, bus_src, xfer_cnt, bus_conflict and conflict_mask.
//     clear_n asserted mid-transfer discards the in-flight value.
//     The first post-reset edge behaves as a normal cycle.
//   Select: combinational priority encoder over src_out; the highest set index k wins.
//     No latch is inferred; the idle case is handled explicitly.
//   Latency: exactly 1 clock, from src_out/src_data sampled at edge N to bus_out valid after edge N.
//   Driven cycle (any src_out bit set, hold_en=0), at the edge:
//     bus_out <= src_data[k]; bus_src <= k; bus_valid <= 1.
//   Idle cycle (src_out == 0, hold_en=0):
//     bus_out and bus_src keep their previous values; bus_valid <= 0.
//   Hold (hold_en=1): every register keeps its value, including xfer_cnt and contention state.
//     hold_en overrides src_out.
//     cnt_clr and conflict_clr are still honoured during hold.
//   xfer_cnt: +1 on each driven, non-held cycle.
//     Saturates at all-ones; no wrap.
//     cnt_clr=1 loads 0. If cnt_clr and a driven cycle coincide, the result is 0 (clear wins).
//   Width rule: bus_src is zero-extended from k; k < NSRC always.
// CONFIGURATION
//   Macro BUS_MUX_CONTENTION_EN.
//   Defined:
//     A conflict exists when popcount(src_out) > 1 and hold_en=0.
//     A conflict sets bus_conflict <= 1 at the edge. The flag is sticky.
//     On the 0->1 transition only, conflict_mask <= src_out. Later conflicts do not overwrite it.
//     conflict_clr=1 clears both. If conflict_clr and a new conflict occur in the same cycle,
//       set wins and conflict_mask captures the new src_out.
//     Priority selection is unaffected by a conflict.
//   Undefined: bus_conflict and conflict_mask are tied to 0; conflict_clr is ignored.
//     Port list is identical in both builds.
// TESTING
//   T1: pulse clear_n low mid-stream -> all outputs 0 immediately, before any clock edge.
//   T2: src_out=1<<3, src_data[3]=32'hDEADBEEF for 1 cycle -> after the next edge
//       bus_out=DEADBEEF, bus_src=3, bus_valid=1, xfer_cnt=1. On the following idle cycle
//       bus_out stays DEADBEEF and bus_valid=0.
//   T3: src_out has bits 2 and 21 set, data 32'h11 and 32'h22 ->
//       bus_out=32'h22, bus_src=21. With the macro: bus_conflict=1 and conflict_mask has
//       bits 2 and 21 set (24'h200004 for NSRC=24).
//       A later conflict on bits 0 and 1 leaves the mask unchanged.
//       conflict_clr -> both cleared.
//   T4: CNT_W=4, 20 consecutive driven cycles -> xfer_cnt stops at 4'hF.
//       cnt_clr together with a driven cycle -> 0.
//   T5: hold_en=1 while src_out=1<<5 with new data -> bus_out, bus_src, bus_valid and
//       xfer_cnt unchanged. After release, the new value appears 1 cycle later.

Source files
------------

// File: rtl/bus_mux_reg.sv
// -----------------------------------------------------------------------------
// bus_mux_reg
//   Registered CPU datapath bus multiplexer. One of NSRC sources is selected
//   onto a WIDTH-bit bus with a fixed priority, where the highest-index active
//   drive enable wins. The selected value is registered, so there is one clock
//   of latency.
//   When no source drives the bus, the bus value and the source index are held.
//   hold_en freezes every register. A saturating counter tracks driven cycles.
//
//   Optional feature: define BUS_MUX_CONTENTION_EN to enable sticky
//   multi-driver contention detection (bus_conflict / conflict_mask). When the
//   macro is undefined, both outputs are tied to 0 and conflict_clr is ignored.
//
// Ports
//   clock          in   system clock, rising edge
//   clear_n        in   asynchronous active-low reset, zeroes all outputs
//   src_out        in   per-source drive enables
//   src_data       in   flattened source data, source i at [i*WIDTH +: WIDTH]
//   hold_en        in   freeze all registered outputs this cycle
//   cnt_clr        in   synchronous clear of xfer_cnt (wins over increment)
//   conflict_clr   in   synchronous clear of contention status
//   bus_out        out  registered bus value
//   bus_valid      out  bus_out was driven by a source in the previous cycle
//   bus_src        out  index of the source that drove bus_out
//   xfer_cnt       out  saturating count of driven cycles
//   bus_conflict   out  sticky multi-driver flag
//   conflict_mask  out  src_out captured at the first conflict
// -----------------------------------------------------------------------------
module bus_mux_reg #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int IDX_W = $clog2(NSRC),
  parameter int CNT_W = 16
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic [NSRC-1:0]         src_out,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic                    hold_en,
  input  logic                    cnt_clr,
  input  logic                    conflict_clr,
  output logic [WIDTH-1:0]        bus_out,
  output logic                    bus_valid,
  output logic [IDX_W-1:0]        bus_src,
  output logic [CNT_W-1:0]        xfer_cnt,
  output logic                    bus_conflict,
  output logic [NSRC-1:0]         conflict_mask
);

  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             any_drive;

  // The scan runs from low to high index, so the last match (the highest
  // index) overwrites any earlier one. The all-zero defaults cover the idle
  // case, so no latch is inferred.
  always_comb begin
    sel_idx   = '0;
    sel_data  = '0;
    any_drive = |src_out;
    for (int i = 0; i < NSRC; i++) begin
      if (src_out[i]) begin
        sel_idx  = IDX_W'(i);
        sel_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // The bus value and the source index only move on a driven cycle. In that
  // case valid drops on idle cycles. hold_en overrides everything, except
  // that the counter clear is still honoured.
  always_comb begin
    bus_d   = bus_q;
    src_d   = src_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!hold_en) begin
      if (any_drive) begin
        bus_d   = sel_data;
        src_d   = sel_idx;
        valid_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        valid_d = 1'b0;
      end
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      bus_q   <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      bus_q   <= bus_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_out   = bus_q;
  assign bus_valid = valid_q;
  assign bus_src   = src_q;
  assign xfer_cnt  = cnt_q;

`ifdef BUS_MUX_CONTENTION_EN
  logic            conflict_q, conflict_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            multi_drive;

  // Clearing the lowest set bit leaves something behind only when two or
  // more enables are set.
  assign multi_drive = (src_out & (src_out - NSRC'(1))) != '0;

  // A new conflict beats a same-cycle clear. The mask is captured only when
  // the flag rises from 0. When a clear coincides with a new conflict, the
  // flag effectively restarts, so the new src_out is captured.
  always_comb begin
    conflict_d = conflict_q;
    mask_d     = mask_q;
    if (conflict_clr) begin
      conflict_d = 1'b0;
      mask_d     = '0;
    end
    if (!hold_en && multi_drive) begin
      conflict_d = 1'b1;
      if (!conflict_q || conflict_clr) begin
        mask_d = src_out;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      conflict_q <= 1'b0;
      mask_q     <= '0;
    end else begin
      conflict_q <= conflict_d;
      mask_q     <= mask_d;
    end
  end

  assign bus_conflict  = conflict_q;
  assign conflict_mask = mask_q;
`else
  logic unused_conflict_clr;
  assign unused_conflict_clr = conflict_clr;
  assign bus_conflict        = 1'b0;
  assign conflict_mask       = '0;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// -----------------------------------------------------------------------------
// tb_bus_mux_reg
//   Scoreboard bench for bus_mux_reg. The DUT is built with CNT_W=4 so that
//   counter saturation is reachable quickly.
//   Each applyStimulus call drives one cycle of inputs on a falling edge. It
//   also queues the hand-computed outputs expected after the next rising edge.
//   The monitor pops one entry per rising edge and compares it against the DUT.
//   Contention expectations collapse to 0 when BUS_MUX_CONTENTION_EN is
//   undefined.
// -----------------------------------------------------------------------------
module tb_bus_mux_reg;

  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam int IDX_W = 5;
  localparam int CNT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] bus;
    logic             valid;
    logic [IDX_W-1:0] src;
    logic [CNT_W-1:0] cnt;
    logic             conf;
    logic [NSRC-1:0]  mask;
  } expT;

  logic                  clock;
  logic                  clear_n;
  logic [NSRC-1:0]       srcOut;
  logic [NSRC*WIDTH-1:0] srcData;
  logic                  holdEn;
  logic                  cntClr;
  logic                  conflictClr;
  logic [WIDTH-1:0]      busOut;
  logic                  busValid;
  logic [IDX_W-1:0]      busSrc;
  logic [CNT_W-1:0]      xferCnt;
  logic                  busConflict;
  logic [NSRC-1:0]       conflictMask;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  bus_mux_reg #(
    .WIDTH(WIDTH), .NSRC(NSRC), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .clear_n(clear_n), .src_out(srcOut), .src_data(srcData),
    .hold_en(holdEn), .cnt_clr(cntClr), .conflict_clr(conflictClr),
    .bus_out(busOut), .bus_valid(busValid), .bus_src(busSrc),
    .xfer_cnt(xferCnt), .bus_conflict(busConflict),
    .conflict_mask(conflictMask)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Absolute watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input expT e);
    checkField({tag, ".bus_out"},       busOut,                e.bus);
    checkField({tag, ".bus_valid"},     32'(busValid),         32'(e.valid));
    checkField({tag, ".bus_src"},       32'(busSrc),           32'(e.src));
    checkField({tag, ".xfer_cnt"},      32'(xferCnt),          32'(e.cnt));
    checkField({tag, ".bus_conflict"},  32'(busConflict),      32'(e.conf));
    checkField({tag, ".conflict_mask"}, 32'(conflictMask),     32'(e.mask));
  endtask

  // Monitor: the registered outputs settle after every rising edge; compare
  // them against the oldest queued expectation.
  always @(posedge clock) begin
    #1;
    if (expQ.size() != 0) begin
      checkOutput("scoreboard", expQ.pop_front());
    end
  end

  task automatic setData(input int idx, input logic [WIDTH-1:0] v);
    srcData[idx*WIDTH +: WIDTH] = v;
  endtask

  task automatic applyStimulus(
    input logic [NSRC-1:0] so, input logic hold, input logic cc,
    input logic fc, input logic [WIDTH-1:0] eBus, input logic eValid,
    input logic [IDX_W-1:0] eSrc, input logic [CNT_W-1:0] eCnt,
    input logic eConf, input logic [NSRC-1:0] eMask);
    expT e;
    @(negedge clock);
    srcOut      = so;
    holdEn      = hold;
    cntClr      = cc;
    conflictClr = fc;
    e.bus   = eBus;
    e.valid = eValid;
    e.src   = eSrc;
    e.cnt   = eCnt;
`ifdef BUS_MUX_CONTENTION_EN
    e.conf  = eConf;
    e.mask  = eMask;
`else
    e.conf  = 1'b0;
    e.mask  = '0;
`endif
    expQ.push_back(e);
  endtask

  expT zeroE;

  initial begin
    zeroE = '{bus: '0, valid: 1'b0, src: '0, cnt: '0, conf: 1'b0, mask: '0};
    clear_n     = 1'b0;
    srcOut      = '0;
    srcData     = '0;
    holdEn      = 1'b0;
    cntClr      = 1'b0;
    conflictClr = 1'b0;

    // Reset state
    #2;
    checkOutput("reset", zeroE);
    #10 clear_n = 1'b1;

    // T2: single driver, then idle hold of bus value
    setData(3, 32'hDEADBEEF);
    applyStimulus(24'h000008, 0, 0, 0, 32'hDEADBEEF, 1, 5'd3, 4'd1, 0, 24'h0);
    applyStimulus(24'h000000, 0, 0, 0, 32'hDEADBEEF, 0, 5'd3, 4'd1, 0, 24'h0);

    // T3: contention, highest index wins, mask sticks to first conflict
    setData(2, 32'h11);
    setData(21, 32'h22);
    applyStimulus(24'h200004, 0, 0, 0, 32'h22, 1, 5'd21, 4'd2, 1, 24'h200004);
    setData(0, 32'h33);
    setData(1, 32'h44);
    applyStimulus(24'h000003, 0, 0, 0, 32'h44, 1, 5'd1, 4'd3, 1, 24'h200004);
    applyStimulus(24'h000000, 0, 0, 1, 32'h44, 0, 5'd1, 4'd3, 0, 24'h0);
    // Clear and a new conflict together: set wins, new mask captured
    applyStimulus(24'h000003, 0, 0, 0, 32'h44, 1, 5'd1, 4'd4, 1, 24'h000003);
    applyStimulus(24'h000021, 0, 0, 1, 32'h00000000, 1, 5'd5, 4'd5, 1, 24'h000021);
    applyStimulus(24'h000000, 0, 0, 1, 32'h00000000, 0, 5'd5, 4'd5, 0, 24'h0);

    // T5: hold freezes everything, then the new value lands one cycle later
    setData(5, 32'hA5A50005);
    applyStimulus(24'h000020, 1, 0, 0, 32'h00000000, 0, 5'd5, 4'd5, 0, 24'h0);
    applyStimulus(24'h000021, 1, 0, 0, 32'h00000000, 0, 5'd5, 4'd5, 0, 24'h0);
    applyStimulus(24'h000020, 0, 0, 0, 32'hA5A50005, 1, 5'd5, 4'd6, 0, 24'h0);
    applyStimulus(24'h000003, 0, 0, 0, 32'h44, 1, 5'd1, 4'd7, 1, 24'h000003);
    // Clears are still honoured while held
    applyStimulus(24'h000000, 1, 0, 1, 32'h44, 1, 5'd1, 4'd7, 0, 24'h0);
    applyStimulus(24'h000020, 1, 1, 0, 32'h44, 1, 5'd1, 4'd0, 0, 24'h0);

    // T4: saturation at 4'hF, then clear beats a driven cycle
    setData(7, 32'h77);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(24'h000080, 0, 0, 0, 32'h77, 1, 5'd7,
                    (i + 1 > 15) ? 4'hF : CNT_W'(i + 1), 0, 24'h0);
    end
    applyStimulus(24'h000080, 0, 1, 0, 32'h77, 1, 5'd7, 4'd0, 0, 24'h0);
    applyStimulus(24'h000080, 0, 0, 0, 32'h77, 1, 5'd7, 4'd1, 0, 24'h0);

    // T1: asynchronous reset mid-stream, checked before any clock edge
    @(negedge clock);
    #2 clear_n = 1'b0;
    #1;
    checkOutput("async_reset", zeroE);
    @(posedge clock);
    #1;
    checkOutput("reset_held", zeroE);
    @(negedge clock);
    srcOut = '0;
    #2 clear_n = 1'b1;

    // First edge after reset is a normal cycle; top index boundary
    setData(23, 32'hCAFE0017);
    applyStimulus(24'h800000, 0, 0, 0, 32'hCAFE0017, 1, 5'd23, 4'd1, 0, 24'h0);
    applyStimulus(24'hFFFFFF, 0, 0, 0, 32'hCAFE0017, 1, 5'd23, 4'd2, 1, 24'hFFFFFF);
    applyStimulus(24'h000000, 0, 0, 0, 32'hCAFE0017, 0, 5'd23, 4'd2, 1, 24'hFFFFFF);

    @(negedge clock);
    @(negedge clock);
    checkField("queue_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
